// File: rtl/rambus_sample_reader_pkg.sv
// Shared types and constants for the rambus sample reader.
package rambus_sample_reader_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH      = 2'd1,
    WAIT_SPACE = 2'd2
  } fsm_state_t;

  localparam logic [3:0] SEL_ALL                = 4'hF;
  localparam int         WORD_STRIDE            = 4;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rambus_sample_reader_if.sv
// Wishbone rambus link between the sample reader (master) and the RAM wrapper port B (slave).
interface rambus_sample_reader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  clk;
  logic                  rst;
  logic                  stb;
  logic                  cyc;
  logic                  we;
  logic [3:0]            sel;
  logic [31:0]           wdata;
  logic [ADDR_WIDTH-1:0] adr;
  logic                  ack;
  logic [31:0]           rdata;

  modport master (
    output clk, rst, stb, cyc, we, sel, wdata, adr,
    input  ack, rdata
  );

  modport slave (
    input  clk, rst, stb, cyc, we, sel, wdata, adr,
    output ack, rdata
  );
endinterface

// File: rtl/rambus_sample_reader_sample_fifo.sv
// Small synchronous FIFO with a combinational head, used to buffer read samples.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_reg.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == PTR_W'(gi))) mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  assign head_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/rambus_sample_reader.sv
// Wishbone initiator that streams words from a circular RAM window into a valid/ready sample FIFO.
module rambus_sample_reader
  import rambus_sample_reader_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  rambus_sample_reader_if.master rambus_wb,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [31:0]           sample_data,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL_COUNT = FCNT_W'(FIFO_DEPTH);
  localparam logic [TCNT_W-1:0] TMO_LAST        = TCNT_W'(TIMEOUT_CYCLES - 1);

  fsm_state_t            state_reg;
  logic                  stb_reg;
  logic                  cyc_reg;
  logic [ADDR_WIDTH-1:0] adr_reg;
  logic [ADDR_WIDTH-1:0] start_reg;
  logic [ADDR_WIDTH-1:0] end_reg;
  logic                  run_prev_reg;
  logic                  timeout_err_reg;
  logic [TCNT_W-1:0]     tmo_cnt_reg;

  logic                  fifo_push;
  logic                  fifo_flush;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  sample_pop;
  logic                  has_space;
  logic                  run_rise;
  logic [ADDR_WIDTH-1:0] adr_next;

  assign sample_pop = sample_valid && sample_ready;
  assign has_space  = (fifo_count < FIFO_FULL_COUNT) || sample_pop;
  assign run_rise   = run && !run_prev_reg;
  // Natural overflow of the adder gives the wrap across the top of the address space.
  assign adr_next   = (adr_reg == end_reg) ? start_reg : adr_reg + ADDR_WIDTH'(WORD_STRIDE);
  assign fifo_push  = (state_reg == FETCH) && stb_reg && rambus_wb.ack && run && !fifo_full;
  assign fifo_flush = (state_reg == IDLE) && !run;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg       <= IDLE;
      stb_reg         <= 1'b0;
      cyc_reg         <= 1'b0;
      adr_reg         <= '0;
      start_reg       <= '0;
      end_reg         <= '0;
      // Treat run as already high so a level held across reset does not restart streaming.
      run_prev_reg    <= 1'b1;
      timeout_err_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      run_prev_reg <= run;
      case (state_reg)
        IDLE: begin
          if (run_rise) begin
            start_reg       <= start_addr;
            end_reg         <= end_addr;
            adr_reg         <= start_addr;
            timeout_err_reg <= 1'b0;
            state_reg       <= has_space ? FETCH : WAIT_SPACE;
          end
        end
        FETCH: begin
          if (!stb_reg) begin
            if (!run) begin
              state_reg <= IDLE;
            end else begin
              stb_reg     <= 1'b1;
              cyc_reg     <= 1'b1;
              tmo_cnt_reg <= '0;
            end
          end else if (rambus_wb.ack) begin
            stb_reg <= 1'b0;
            cyc_reg <= 1'b0;
            if (run) begin
              adr_reg   <= adr_next;
              state_reg <= WAIT_SPACE;
            end else begin
              state_reg <= IDLE;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            stb_reg         <= 1'b0;
            cyc_reg         <= 1'b0;
            timeout_err_reg <= 1'b1;
            state_reg       <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        WAIT_SPACE: begin
          if (!run) begin
            state_reg <= IDLE;
          end else if (has_space) begin
            state_reg   <= FETCH;
            stb_reg     <= 1'b1;
            cyc_reg     <= 1'b1;
            tmo_cnt_reg <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          stb_reg   <= 1'b0;
          cyc_reg   <= 1'b0;
        end
      endcase
    end
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (rambus_wb.rdata),
    .pop       (sample_pop),
    .head_data (sample_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign sample_valid = !fifo_empty;
  assign busy         = (state_reg != IDLE);
  assign timeout_err  = timeout_err_reg;

  assign rambus_wb.clk   = wb_clk_i;
  assign rambus_wb.rst   = wb_rst_i;
  assign rambus_wb.stb   = stb_reg;
  assign rambus_wb.cyc   = cyc_reg;
  assign rambus_wb.we    = 1'b0;
  assign rambus_wb.sel   = SEL_ALL;
  assign rambus_wb.wdata = '0;
  assign rambus_wb.adr   = adr_reg;

endmodule

// File: tb/tb_rambus_sample_reader.sv
// Directed bench for rambus_sample_reader with a Wishbone RAM responder of configurable ack latency.
module tb_rambus_sample_reader;
  logic        clk;
  logic        rst;
  logic        run;
  logic [9:0]  start_addr;
  logic [9:0]  end_addr;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sample_data;
  logic        busy;
  logic        timeout_err;

  rambus_sample_reader_if #(.ADDR_WIDTH(10)) bus ();

  rambus_sample_reader #(
    .ADDR_WIDTH     (10),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .run          (run),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .rambus_wb    (bus.master),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [256];
  int          ack_delay = 0;
  logic        never_ack = 1'b0;
  int          wait_cnt;

  logic [9:0]  adr_log [$];
  logic [31:0] smp_log [$];
  int          n_cyc = 0;
  int          n_bad_ctl = 0;
  logic        cyc_prev = 1'b0;

  logic [31:0] exp_d [5];
  logic [9:0]  exp_a [5];

  // RAM responder: registered single-cycle ack after ack_delay cycles of strobe.
  always @(posedge clk or posedge bus.rst) begin
    if (bus.rst) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      wait_cnt  <= 0;
    end else if (bus.ack) begin
      bus.ack <= 1'b0;
    end else if (bus.cyc && bus.stb && !never_ack) begin
      if (wait_cnt >= ack_delay) begin
        bus.ack   <= 1'b1;
        bus.rdata <= mem[bus.adr[9:2]];
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (bus.cyc && bus.stb && bus.ack) adr_log.push_back(bus.adr);
    if (sample_valid && sample_ready) smp_log.push_back(sample_data);
    if (bus.cyc && !cyc_prev) n_cyc <= n_cyc + 1;
    if (bus.cyc && (bus.we !== 1'b0 || bus.sel !== 4'hF || bus.wdata !== 32'h0))
      n_bad_ctl <= n_bad_ctl + 1;
    cyc_prev <= bus.cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stop_run();
    run = 1'b0;
    repeat (10) step();
  endtask

  int ab, sb, cb, cnt;
  logic hold_ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | i;
    mem[0]   = 32'h11111111;
    mem[1]   = 32'h22222222;
    mem[2]   = 32'h33333333;
    mem[3]   = 32'h44444444;
    mem[254] = 32'h5A5A03F8;
    mem[255] = 32'h5A5A03FC;

    rst = 1'b1; run = 1'b0; start_addr = '0; end_addr = '0; sample_ready = 1'b0;
    #3;
    check_eq("rst_stb", bus.stb, 0);
    check_eq("rst_cyc", bus.cyc, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_valid", sample_valid, 0);
    check_eq("rst_adr", bus.adr, 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // Stream basic over words 0..3.
    start_addr = 10'h000; end_addr = 10'h00C; sample_ready = 1'b1;
    ab = adr_log.size(); sb = smp_log.size();
    run = 1'b1;
    step();
    check_eq("rise_stb_lo", bus.stb, 0);
    step();
    check_eq("rise_stb_hi", bus.stb, 1);
    for (int i = 0; i < 300 && smp_log.size() < sb + 5; i++) step();
    check_eq("stream_count", smp_log.size() >= sb + 5, 1);
    exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h11111111};
    exp_a = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h000};
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stream_smp%0d", i), smp_log[sb + i], exp_d[i]);
      check_eq($sformatf("stream_adr%0d", i), 32'(adr_log[ab + i]), 32'(exp_a[i]));
    end
    stop_run();
    check_eq("stream_stop_busy", busy, 0);

    // Backpressure: FIFO fills after 4 reads, one pop buys one more read.
    sample_ready = 1'b0;
    ab = adr_log.size(); sb = smp_log.size(); cb = n_cyc;
    run = 1'b1;
    for (int i = 0; i < 50 && bus.ack !== 1'b1; i++) step();
    check_eq("bp_first_ack_seen", bus.ack, 1);
    check_eq("bp_valid_before", sample_valid, 0);
    step();
    check_eq("bp_valid_after", sample_valid, 1);
    repeat (60) step();
    check_eq("bp_reads", adr_log.size() - ab, 4);
    check_eq("bp_cycles", n_cyc - cb, 4);
    check_eq("bp_cyc_idle", bus.cyc, 0);
    check_eq("bp_head_stable", sample_data, 32'h11111111);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    repeat (30) step();
    check_eq("bp_reads_after_pop", adr_log.size() - ab, 5);
    check_eq("bp_fifth_adr", 32'(adr_log[ab + 4]), 32'h000);
    check_eq("bp_popped", smp_log[sb], 32'h11111111);
    check_eq("bp_new_head", sample_data, 32'h22222222);
    stop_run();
    check_eq("bp_flushed", sample_valid, 0);

    // Window wrapping across the top of the address space.
    start_addr = 10'h3F8; end_addr = 10'h004; sample_ready = 1'b1;
    ab = adr_log.size(); sb = smp_log.size();
    run = 1'b1;
    for (int i = 0; i < 300 && adr_log.size() < ab + 5; i++) step();
    exp_a = '{10'h3F8, 10'h3FC, 10'h000, 10'h004, 10'h3F8};
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("wrap_adr%0d", i), 32'(adr_log[ab + i]), 32'(exp_a[i]));
    check_eq("wrap_smp2", smp_log[sb + 2], 32'h11111111);
    stop_run();

    // Run falls mid-cycle: cycle completes, data discarded.
    start_addr = 10'h000; end_addr = 10'h00C; ack_delay = 5;
    sb = smp_log.size();
    run = 1'b1;
    for (int i = 0; i < 20 && bus.stb !== 1'b1; i++) step();
    check_eq("stop_stb_seen", bus.stb, 1);
    step();
    step();
    run = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 20 && bus.ack !== 1'b1; i++) begin
      if (bus.stb !== 1'b1 || bus.cyc !== 1'b1) hold_ok = 1'b0;
      step();
    end
    check_eq("stop_held", hold_ok, 1);
    check_eq("stop_ack_seen", bus.ack, 1);
    step();
    check_eq("stop_cyc_drop", bus.cyc, 0);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_valid", sample_valid, 0);
    check_eq("stop_no_push", smp_log.size() - sb, 0);
    repeat (5) step();
    ack_delay = 0;

    // Timeout with a silent responder.
    never_ack = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 20 && bus.stb !== 1'b1; i++) step();
    cnt = 0;
    for (int i = 0; i < 400 && bus.stb === 1'b1; i++) begin
      cnt++;
      step();
    end
    check_eq("tmo_stb_cycles", cnt, 255);
    check_eq("tmo_err", timeout_err, 1);
    check_eq("tmo_busy", busy, 0);
    repeat (10) step();
    check_eq("tmo_sticky", timeout_err, 1);
    check_eq("tmo_no_retry", bus.cyc, 0);
    never_ack = 1'b0;
    run = 1'b0;
    repeat (2) step();
    run = 1'b1;
    repeat (2) step();
    check_eq("tmo_cleared", timeout_err, 0);
    stop_run();

    // Asynchronous reset mid-FETCH with two samples queued.
    ack_delay = 3; sample_ready = 1'b0;
    ab = adr_log.size();
    run = 1'b1;
    for (int i = 0; i < 100 && adr_log.size() < ab + 2; i++) step();
    for (int i = 0; i < 20 && !(bus.stb === 1'b1 && bus.ack === 1'b0); i++) step();
    check_eq("rst2_pre_stb", bus.stb, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst2_stb", bus.stb, 0);
    check_eq("rst2_cyc", bus.cyc, 0);
    check_eq("rst2_valid", sample_valid, 0);
    repeat (2) step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cyc === 1'b1) cnt++;
      step();
    end
    check_eq("rst2_quiet", cnt, 0);
    run = 1'b0;
    repeat (2) step();
    run = 1'b1;
    for (int i = 0; i < 10 && bus.stb !== 1'b1; i++) step();
    check_eq("rst2_restart", bus.stb, 1);
    stop_run();

    check_eq("ctl_constants", n_bad_ctl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rambus_sample_reader.md
Name: rambus_sample_reader

Overview:
Wishbone initiator on the user-project rambus. It is the master end that drives port B of the dual-port OpenRAM wrapper. While run is high, it reads 32-bit words sequentially from a programmable circular address window. Each word goes into a small FIFO that feeds a valid/ready sample stream (e.g. the function generator DAC path). The design has one clock, no outstanding-transaction pipelining, and a bounded ack timeout.

Parameters:
ADDR_WIDTH, 10, rambus byte address width (1 kB RAM, word-aligned, bits [1:0] always 0)
FIFO_DEPTH, 4, sample FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 255, cycles to wait for ack before aborting a cycle

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset, asynchronous, active-high
run  in  1  level; high = stream, low = stop and flush
start_addr  in  ADDR_WIDTH  first word byte address of window (sampled on run rise)
end_addr  in  ADDR_WIDTH  last word byte address, inclusive (sampled on run rise)
rambus_wb_clk_o  out  1  = wb_clk_i
rambus_wb_rst_o  out  1  = wb_rst_i
rambus_wb_stb_o  out  1  strobe
rambus_wb_cyc_o  out  1  cycle
rambus_wb_we_o  out  1  constant 0
rambus_wb_sel_o  out  4  constant 4'hF
rambus_wb_dat_o  out  32  constant 0
rambus_wb_adr_o  out  ADDR_WIDTH  read address
rambus_wb_ack_i  in  1  ack from RAM wrapper
rambus_wb_dat_i  in  32  read data
sample_valid  out  1  FIFO non-empty
sample_ready  in  1  consumer accepts head
sample_data  out  32  FIFO head
busy  out  1  FSM not IDLE
timeout_err  out  1  sticky; cleared on run rise or reset

Behaviour:
- Reset values: stb, cyc, busy, timeout_err, sample_valid = 0; adr = 0; FIFO empty; state IDLE.
- All bus outputs are registered. We, sel and dat_o are constants.
- State IDLE:
  - On a run rising edge (run=1, previous run=0), latch start_addr and end_addr.
  - Set adr to start_addr and clear timeout_err.
  - Go to FETCH if the FIFO has space, else WAIT_SPACE.
- State FETCH:
  - cyc=stb=1, adr held, timeout counter running.
  - On ack_i:
    - Push dat_i into the FIFO and drop cyc/stb on the next edge.
    - adr becomes start_addr if adr==end_addr, else adr+4. Wrap modulo 2^ADDR_WIDTH if end_addr<start_addr.
    - Go to WAIT_SPACE.
  - If the counter reaches TIMEOUT_CYCLES without ack: drop cyc/stb, set timeout_err, go to IDLE.
- State WAIT_SPACE (at most one outstanding read):
  - cyc=stb=0 for at least 1 cycle.
  - Re-enter FETCH when the FIFO count is below FIFO_DEPTH, counting a same-cycle pop.
- Timing: minimum 1 idle cycle between bus cycles.
  - run rise at edge N -> stb high after edge N+1.
  - ack at edge M -> sample_valid high after edge M.
- run falls while in FETCH: the cycle is not aborted. Hold cyc/stb until ack or timeout, discard that data, then go to IDLE.
- run falls in any other state: go to IDLE on the next edge.
- On entry to IDLE from run=0, the FIFO is flushed.
- FIFO:
  - Push and pop in the same cycle leaves the count unchanged.
  - A pop with sample_valid=0 is ignored.
  - Push never occurs when full, because space is reserved before FETCH.
  - sample_data is stable while sample_valid=1 and sample_ready=0.
- Window of a single word (start==end): the same address is re-read continuously.
- Asynchronous reset mid-cycle: cyc/stb drop immediately and the FIFO is emptied.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, FETCH, WAIT_SPACE).
  - SEL_ALL=4'hF, WORD_STRIDE=4.
  - Default TIMEOUT_CYCLES.
- One sub-module: sample_fifo (synchronous FIFO with DEPTH/WIDTH parameters, push/pop/count/full/empty, async active-high reset).

Test Plan:
- Stream basic:
  - Stimulus: RAM words 0..3 preloaded with 0x11111111..0x44444444; start=0x000, end=0x00C; run=1; sample_ready=1.
  - Required: samples 0x111..,0x222..,0x333..,0x444..,0x111.. in order; adr sequence 0x000,0x004,0x008,0x00C,0x000; we_o always 0, sel_o always 4'hF.
- Backpressure:
  - Stimulus: sample_ready=0 with FIFO_DEPTH=4.
  - Required: exactly 4 bus cycles, then cyc stays 0; raising ready for one cycle triggers exactly one more read.
- Wrap across top:
  - Stimulus: start=0x3F8, end=0x004.
  - Required: adr sequence 0x3F8,0x3FC,0x000,0x004,0x3F8.
- Stop mid-cycle:
  - Stimulus: responder delays ack 5 cycles; run drops 2 cycles into FETCH.
  - Required: cyc/stb held until ack, data not pushed, FIFO empty, busy=0 the cycle after.
- Timeout:
  - Stimulus: responder never acks.
  - Required: cyc/stb drop after 255 cycles, timeout_err=1 sticky; a new run rise clears it.
- Reset:
  - Stimulus: wb_rst_i asserted mid-FETCH with FIFO holding 2 entries.
  - Required: stb/cyc/sample_valid go 0 asynchronously; after release, no bus activity until the next run rise.
